text_writer: RTL and testbench
==============================

# text_writer

Upstream feeder for the text video memory: accepts a byte stream over a valid/ready handshake, interprets printable characters and a small control-code set, and issues single-cycle cell writes (`write`, `xtextwrite`, `ytextwrite`, `value`) into the video memory write port. It tracks a hardware cursor and the current attribute, and can sequence a full-screen clear. Sits between the host byte source (UART receiver or test pattern generator) and `video_memory`.

## Interface
- `COLS`, 100, text columns per row.
- `ROWS`, 37, text rows per screen.
- `XW`, 7, width of column coordinate; must satisfy 2^XW >= COLS.
- `YW`, 6, width of row coordinate; must satisfy 2^YW >= ROWS.
- `ATTR_RESET`, 8'h07, attribute after reset: fg white, bg black, no blink, no underline.

- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `in_data`  in  8  incoming byte.
- `in_valid`  in  1  `in_data` valid.
- `in_ready`  out  1  block can accept a byte this cycle.
- `write`  out  1  one-cycle write strobe to video memory.
- `xtextwrite`  out  XW  target column.
- `ytextwrite`  out  YW  target row.
- `value`  out  16  cell word: [7:0] character index, [15:8] attribute (attr[2:0] fg, [5:3] bg, [6] blink, [7] underline).
- `cursor_x`  out  XW  current cursor column.
- `cursor_y`  out  YW  current cursor row.
- `busy`  out  1  high while a clear sequence runs.

## Operation
- Byte accepted when `in_valid & in_ready`. States: IDLE, ESC, CLEAR.
- IDLE, accepted byte:
  - 0x20–0xFF except 0x1B: write {attr, byte} at cursor; cursor advances; at x=COLS-1 go to x=0, y+1; at (COLS-1, ROWS-1) wrap to (0,0). No scrolling.
  - 0x0D CR: x=0. 0x0A LF: y+1, wrap ROWS-1→0, x unchanged.
  - 0x08 BS: x-1; at x=0 and y>0 go to (COLS-1, y-1); at (0,0) no change. No write.
  - 0x0C FF: enter CLEAR (see Configuration).
  - 0x1B: enter ESC. Other 0x00–0x1F: ignored, accepted, no write.
- ESC: next accepted byte, any value including 0x1B, loads attribute; return to IDLE. No write.
- CLEAR: `in_ready`=0, `busy`=1; write {attr, 8'h20} to every cell, row-major from (0,0) to (COLS-1, ROWS-1), one cell per cycle; then cursor=(0,0), return to IDLE.
- `in_ready` = 1 in IDLE and ESC, 0 in CLEAR.

## Timing
- Reset values: `write`=0, `xtextwrite`=0, `ytextwrite`=0, `value`=0, `cursor_x`=0, `cursor_y`=0, `busy`=0, `in_ready`=1, attribute=ATTR_RESET, state=IDLE.
- Printable byte accepted on cycle N: `write`=1 with coordinates and value on cycle N+1 only; cursor update visible on N+1. Back-to-back bytes produce writes on consecutive cycles.
- FF accepted on cycle N: `busy` and `in_ready`=0 from N+1; writes on N+1 … N+COLS*ROWS; `busy` drops and cursor reads (0,0) on N+COLS*ROWS+1, same cycle `in_ready` returns to 1.
- All outputs registered; no combinational path from `in_valid` to any output except none (`in_ready` depends on state only).
- Reset asserted mid-CLEAR or in ESC: immediate return to reset values; partial clear is abandoned.

## Configuration
- `TEXT_WRITER_CLEAR_EN` defined: CLEAR state and cell sequencer compiled in, FF behaves as above.
- Not defined: no CLEAR state; FF only homes cursor to (0,0) on cycle N+1, no writes; `busy` tied 0, `in_ready` constant 1.

## Test plan
- Reset, send 'A' (0x41) -> one `write` pulse, x=0, y=0, value=16'h0741; cursor (1,0).
- Send ESC, 0x1C, 'B' -> no write for ESC/0x1C; write of 16'h1C42 at (1,0).
- Cursor at (99,36), send 'Z' -> write at (99,36), cursor wraps to (0,0); then BS at (0,0) -> cursor stays (0,0).
- Cursor (5,3): CR -> (0,3); LF -> (0,4); BS -> (99,3).
- With macro: FF -> exactly 3700 write pulses of value 16'h0720 covering all cells once, `in_ready`=0 throughout, cursor (0,0) after; without macro: FF -> zero writes, cursor (0,0) next cycle.
- Assert reset 100 cycles into CLEAR -> `write`, `busy` drop immediately, attribute back to 8'h07, `in_ready`=1.

Source files
------------

// File: rtl/text_writer.sv
// Byte-stream front end for the text video memory: prints characters, handles control codes and tracks cursor/attribute.
// Optional full-screen clear sequencer is compiled in when TEXT_WRITER_CLEAR_EN is defined.
module text_writer #(
  parameter int         COLS       = 100,
  parameter int         ROWS       = 37,
  parameter int         XW         = 7,
  parameter int         YW         = 6,
  parameter logic [7:0] ATTR_RESET = 8'h07
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          write,
  output logic [XW-1:0] xtextwrite,
  output logic [YW-1:0] ytextwrite,
  output logic [15:0]   value,
  output logic [XW-1:0] cursor_x,
  output logic [YW-1:0] cursor_y,
  output logic          busy
);

  localparam logic [XW-1:0] X_LAST = XW'(COLS - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(ROWS - 1);
  localparam logic [XW-1:0] X_ZERO = {XW{1'b0}};
  localparam logic [YW-1:0] Y_ZERO = {YW{1'b0}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ESC   = 2'd1,
    S_CLEAR = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    attr_q, attr_d;
  logic [XW-1:0] cur_x_q, cur_x_d, wr_x_q, wr_x_d;
  logic [YW-1:0] cur_y_q, cur_y_d, wr_y_q, wr_y_d;
  logic [15:0]   value_q, value_d;
  logic          write_q, write_d;
  logic          accept_s;
`ifdef TEXT_WRITER_CLEAR_EN
  logic          busy_q, busy_d;
`endif

  assign accept_s = in_valid & in_ready;

`ifdef TEXT_WRITER_CLEAR_EN
  assign in_ready = (state_q != S_CLEAR);
  assign busy     = busy_q;
`else
  assign in_ready = 1'b1;
  assign busy     = 1'b0;
`endif

  assign write      = write_q;
  assign xtextwrite = wr_x_q;
  assign ytextwrite = wr_y_q;
  assign value      = value_q;
  assign cursor_x   = cur_x_q;
  assign cursor_y   = cur_y_q;

  // Next-state decode: byte interpretation, cursor motion and clear sequencing
  always_comb begin
    state_d = state_q;
    attr_d  = attr_q;
    cur_x_d = cur_x_q;
    cur_y_d = cur_y_q;
    wr_x_d  = wr_x_q;
    wr_y_d  = wr_y_q;
    value_d = value_q;
    write_d = 1'b0;
`ifdef TEXT_WRITER_CLEAR_EN
    busy_d  = busy_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          if (in_data == 8'h1B) begin
            state_d = S_ESC;
          end else if (in_data >= 8'h20) begin
            write_d = 1'b1;
            wr_x_d  = cur_x_q;
            wr_y_d  = cur_y_q;
            value_d = {attr_q, in_data};
            if (cur_x_q == X_LAST) begin
              cur_x_d = X_ZERO;
              cur_y_d = (cur_y_q == Y_LAST) ? Y_ZERO : cur_y_q + 1'b1;
            end else begin
              cur_x_d = cur_x_q + 1'b1;
            end
          end else begin
            case (in_data)
              8'h0D: cur_x_d = X_ZERO;
              8'h0A: cur_y_d = (cur_y_q == Y_LAST) ? Y_ZERO : cur_y_q + 1'b1;
              8'h08: begin
                if (cur_x_q != X_ZERO) begin
                  cur_x_d = cur_x_q - 1'b1;
                end else if (cur_y_q != Y_ZERO) begin
                  cur_x_d = X_LAST;
                  cur_y_d = cur_y_q - 1'b1;
                end else begin
                  cur_x_d = cur_x_q;
                end
              end
              8'h0C: begin
`ifdef TEXT_WRITER_CLEAR_EN
                // First blank cell goes out on the same edge that enters CLEAR
                state_d = S_CLEAR;
                busy_d  = 1'b1;
                write_d = 1'b1;
                wr_x_d  = X_ZERO;
                wr_y_d  = Y_ZERO;
                value_d = {attr_q, 8'h20};
`else
                cur_x_d = X_ZERO;
                cur_y_d = Y_ZERO;
`endif
              end
              default: cur_x_d = cur_x_q;
            endcase
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ESC: begin
        if (accept_s) begin
          attr_d  = in_data;
          state_d = S_IDLE;
        end else begin
          state_d = S_ESC;
        end
      end
`ifdef TEXT_WRITER_CLEAR_EN
      S_CLEAR: begin
        if ((wr_x_q == X_LAST) && (wr_y_q == Y_LAST)) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          cur_x_d = X_ZERO;
          cur_y_d = Y_ZERO;
        end else begin
          write_d = 1'b1;
          value_d = {attr_q, 8'h20};
          if (wr_x_q == X_LAST) begin
            wr_x_d = X_ZERO;
            wr_y_d = wr_y_q + 1'b1;
          end else begin
            wr_x_d = wr_x_q + 1'b1;
          end
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // State, cursor, attribute and write-port registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      attr_q  <= ATTR_RESET;
      cur_x_q <= X_ZERO;
      cur_y_q <= Y_ZERO;
      wr_x_q  <= X_ZERO;
      wr_y_q  <= Y_ZERO;
      value_q <= 16'h0000;
      write_q <= 1'b0;
`ifdef TEXT_WRITER_CLEAR_EN
      busy_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      attr_q  <= attr_d;
      cur_x_q <= cur_x_d;
      cur_y_q <= cur_y_d;
      wr_x_q  <= wr_x_d;
      wr_y_q  <= wr_y_d;
      value_q <= value_d;
      write_q <= write_d;
`ifdef TEXT_WRITER_CLEAR_EN
      busy_q  <= busy_d;
`endif
    end
  end

endmodule

// File: tb/tb_text_writer.sv
// Scoreboard bench for text_writer: expected cell writes are queued as bytes are sent and popped by a write monitor.
module tb_text_writer;
  localparam int COLS = 100;
  localparam int ROWS = 37;
  localparam int XW   = 7;
  localparam int YW   = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic          write;
  logic [XW-1:0] xtextwrite;
  logic [YW-1:0] ytextwrite;
  logic [15:0]   value;
  logic [XW-1:0] cursor_x;
  logic [YW-1:0] cursor_y;
  logic          busy;

  text_writer #(.COLS(COLS), .ROWS(ROWS), .XW(XW), .YW(YW), .ATTR_RESET(8'h07)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .write(write), .xtextwrite(xtextwrite), .ytextwrite(ytextwrite), .value(value),
    .cursor_x(cursor_x), .cursor_y(cursor_y), .busy(busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int wr_count = 0;
  int cyc = 0;
  int wr_cyc[$];
  logic [XW+YW+15:0] sb[$];
  logic [7:0] m_attr = 8'h07;
  int mx = 0;
  int my = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Write monitor: every write strobe must match the oldest expected cell write
  initial begin
    logic [XW+YW+15:0] exp_w;
    forever begin
      @(negedge clk);
      if (reset === 1'b0 && write === 1'b1) begin
        wr_count++;
        wr_cyc.push_back(cyc);
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected_write: got x=%0d y=%0d value=%h, required no write", xtextwrite, ytextwrite, value);
        end else begin
          exp_w = sb.pop_front();
          if ({xtextwrite, ytextwrite, value} !== exp_w) begin
            errors++;
            $display("FAIL sb_write: got x=%0d y=%0d value=%h, required x=%0d y=%0d value=%h",
                     xtextwrite, ytextwrite, value, exp_w[XW+YW+15:YW+16], exp_w[YW+15:16], exp_w[15:0]);
          end
        end
      end
    end
  end

  task automatic send(input logic [7:0] b);
    int guard;
    guard = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 5000) begin
      checks++; errors++;
      $display("FAIL send_timeout: in_ready=%b, required 1 within 5000 cycles", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic put_char(input logic [7:0] b);
    sb.push_back({XW'(mx), YW'(my), m_attr, b});
    if (mx == COLS - 1) begin
      mx = 0;
      my = (my == ROWS - 1) ? 0 : my + 1;
    end else begin
      mx++;
    end
    send(b);
  endtask

  task automatic put_lf();
    my = (my == ROWS - 1) ? 0 : my + 1;
    send(8'h0A);
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    @(negedge clk);
    checks++; if (write !== 1'b0) begin errors++; $display("FAIL reset_write: got %b, required 0", write); end
    checks++; if (xtextwrite !== 7'd0 || ytextwrite !== 6'd0) begin errors++; $display("FAIL reset_wr_xy: got %0d,%0d, required 0,0", xtextwrite, ytextwrite); end
    checks++; if (value !== 16'h0000) begin errors++; $display("FAIL reset_value: got %h, required 0000", value); end
    checks++; if (cursor_x !== 7'd0 || cursor_y !== 6'd0) begin errors++; $display("FAIL reset_cursor: got %0d,%0d, required 0,0", cursor_x, cursor_y); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b, required 1", in_ready); end
    mx = 0; my = 0; m_attr = 8'h07;
  endtask

  task automatic test_print();
    int w0;
    w0 = wr_count;
    put_char(8'h41);
    checks++; if (write !== 1'b1 || value !== 16'h0741 || xtextwrite !== 7'd0 || ytextwrite !== 6'd0) begin
      errors++; $display("FAIL print_A: got write=%b value=%h x=%0d y=%0d, required 1 0741 0 0", write, value, xtextwrite, ytextwrite); end
    checks++; if (cursor_x !== 7'd1 || cursor_y !== 6'd0) begin errors++; $display("FAIL print_cursor: got %0d,%0d, required 1,0", cursor_x, cursor_y); end
    @(posedge clk); #1;
    checks++; if (write !== 1'b0) begin errors++; $display("FAIL print_pulse: got write=%b, required 0", write); end
    @(negedge clk);
    checks++; if (wr_count - w0 != 1) begin errors++; $display("FAIL print_count: got %0d writes, required 1", wr_count - w0); end
  endtask

  task automatic test_esc();
    int w0;
    w0 = wr_count;
    send(8'h1B);
    send(8'h1C);
    m_attr = 8'h1C;
    put_char(8'h42);
    checks++; if (value !== 16'h1C42 || xtextwrite !== 7'd1 || ytextwrite !== 6'd0) begin
      errors++; $display("FAIL esc_B: got value=%h x=%0d y=%0d, required 1C42 1 0", value, xtextwrite, ytextwrite); end
    @(negedge clk);
    checks++; if (wr_count - w0 != 1) begin errors++; $display("FAIL esc_count: got %0d writes, required 1", wr_count - w0); end
    send(8'h1B); send(8'h07); m_attr = 8'h07;
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 36; i++) put_lf();
    while (mx != COLS - 1) put_char(8'h2E);
    checks++; if (cursor_x !== 7'd99 || cursor_y !== 6'd36) begin errors++; $display("FAIL wrap_pre: got %0d,%0d, required 99,36", cursor_x, cursor_y); end
    put_char(8'h5A);
    checks++; if (value !== 16'h075A || xtextwrite !== 7'd99 || ytextwrite !== 6'd36) begin
      errors++; $display("FAIL wrap_Z: got value=%h x=%0d y=%0d, required 075A 99 36", value, xtextwrite, ytextwrite); end
    checks++; if (cursor_x !== 7'd0 || cursor_y !== 6'd0) begin errors++; $display("FAIL wrap_cursor: got %0d,%0d, required 0,0", cursor_x, cursor_y); end
    send(8'h08);
    checks++; if (cursor_x !== 7'd0 || cursor_y !== 6'd0) begin errors++; $display("FAIL bs_origin: got %0d,%0d, required 0,0", cursor_x, cursor_y); end
  endtask

  task automatic test_ctrl();
    int w0;
    for (int i = 0; i < 3; i++) put_lf();
    for (int i = 0; i < 5; i++) put_char(8'h61 + 8'(i));
    @(negedge clk);
    w0 = wr_count;
    send(8'h01);
    checks++; if (cursor_x !== 7'd5 || cursor_y !== 6'd3) begin errors++; $display("FAIL ctrl_ignored: got %0d,%0d, required 5,3", cursor_x, cursor_y); end
    send(8'h0D);
    checks++; if (cursor_x !== 7'd0 || cursor_y !== 6'd3) begin errors++; $display("FAIL ctrl_cr: got %0d,%0d, required 0,3", cursor_x, cursor_y); end
    send(8'h0A);
    checks++; if (cursor_x !== 7'd0 || cursor_y !== 6'd4) begin errors++; $display("FAIL ctrl_lf: got %0d,%0d, required 0,4", cursor_x, cursor_y); end
    send(8'h08);
    checks++; if (cursor_x !== 7'd99 || cursor_y !== 6'd3) begin errors++; $display("FAIL ctrl_bs: got %0d,%0d, required 99,3", cursor_x, cursor_y); end
    @(negedge clk);
    checks++; if (wr_count != w0) begin errors++; $display("FAIL ctrl_nowrite: got %0d writes, required 0", wr_count - w0); end
    mx = 99; my = 3;
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    wr_cyc.delete();
    put_char(8'h31); put_char(8'h32); put_char(8'h33);
    @(negedge clk);
    checks++; if (wr_cyc.size() != 3) begin errors++; $display("FAIL b2b_count: got %0d writes, required 3", wr_cyc.size()); end
    else begin
      checks++; if (wr_cyc[2] - wr_cyc[0] != 2) begin errors++; $display("FAIL b2b_spacing: got span %0d cycles, required 2", wr_cyc[2] - wr_cyc[0]); end
    end
    checks++; if (cursor_x !== 7'(mx) || cursor_y !== 6'(my)) begin errors++; $display("FAIL b2b_cursor: got %0d,%0d, required %0d,%0d", cursor_x, cursor_y, mx, my); end
  endtask

  task automatic test_clear();
    int w0, k, bad;
    @(negedge clk);
    w0 = wr_count;
`ifdef TEXT_WRITER_CLEAR_EN
    for (int y = 0; y < ROWS; y++)
      for (int x = 0; x < COLS; x++)
        sb.push_back({XW'(x), YW'(y), m_attr, 8'h20});
    send(8'h0C);
    checks++; if (busy !== 1'b1 || in_ready !== 1'b0 || write !== 1'b1) begin
      errors++; $display("FAIL clear_start: got busy=%b in_ready=%b write=%b, required 1 0 1", busy, in_ready, write); end
    k = 1; bad = 0;
    while (busy === 1'b1 && k < 4000) begin
      if (in_ready !== 1'b0) bad++;
      @(posedge clk); #1;
      k++;
    end
    checks++; if (k != COLS * ROWS + 1) begin errors++; $display("FAIL clear_length: got busy low at N+%0d, required N+%0d", k, COLS * ROWS + 1); end
    checks++; if (bad != 0) begin errors++; $display("FAIL clear_in_ready: got %0d cycles with in_ready=1, required 0", bad); end
    checks++; if (in_ready !== 1'b1 || cursor_x !== 7'd0 || cursor_y !== 6'd0) begin
      errors++; $display("FAIL clear_end: got in_ready=%b cursor=%0d,%0d, required 1 0,0", in_ready, cursor_x, cursor_y); end
    @(negedge clk);
    checks++; if (wr_count - w0 != COLS * ROWS) begin errors++; $display("FAIL clear_count: got %0d writes, required %0d", wr_count - w0, COLS * ROWS); end
`else
    send(8'h0C);
    checks++; if (cursor_x !== 7'd0 || cursor_y !== 6'd0 || write !== 1'b0) begin
      errors++; $display("FAIL ff_home: got cursor=%0d,%0d write=%b, required 0,0 0", cursor_x, cursor_y, write); end
    repeat (3) @(negedge clk);
    checks++; if (wr_count != w0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL ff_nowrite: got writes=%0d busy=%b in_ready=%b, required 0 0 1", wr_count - w0, busy, in_ready); end
`endif
    mx = 0; my = 0;
  endtask

  task automatic test_reset_midway();
    send(8'h1B); send(8'h1C); m_attr = 8'h1C;
`ifdef TEXT_WRITER_CLEAR_EN
    for (int i = 0; i < COLS * ROWS; i++) sb.push_back({XW'(i % COLS), YW'(i / COLS), m_attr, 8'h20});
    send(8'h0C);
    repeat (99) @(posedge clk);
    #2;
    checks++; if (write !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL midclear_pre: got write=%b busy=%b, required 1 1", write, busy); end
`else
    send(8'h1B);
    #1;
`endif
    reset = 1'b1;
    #1;
    checks++; if (write !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_mid: got write=%b busy=%b in_ready=%b, required 0 0 1", write, busy, in_ready); end
    @(negedge clk) reset = 1'b0;
    sb.delete();
    m_attr = 8'h07; mx = 0; my = 0;
    put_char(8'h44);
    checks++; if (value !== 16'h0744 || xtextwrite !== 7'd0 || ytextwrite !== 6'd0) begin
      errors++; $display("FAIL reset_attr: got value=%h x=%0d y=%0d, required 0744 0 0", value, xtextwrite, ytextwrite); end
  endtask

  initial begin
    test_reset();
    test_print();
    test_esc();
    test_wrap();
    test_ctrl();
    test_back_to_back();
    test_clear();
    test_reset_midway();
    repeat (2) @(negedge clk);
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL sb_drain: got %0d pending writes, required 0", sb.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
